// File: rtl/nand_pipe_pkg.sv
// Opcode encoding and 2-input NAND primitives shared by the NAND logic pipe.
package nand_pipe_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NAND   = 3'd0;
    localparam logic [OP_W-1:0] OP_AND    = 3'd1;
    localparam logic [OP_W-1:0] OP_OR     = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // AND composed from two NAND cells.
    function automatic logic and2(input logic x, input logic y);
        return nand2(nand2(x, y), nand2(x, y));
    endfunction

endpackage

// File: rtl/nand_fn_unit.sv
// Combinational logic unit: every gate function and the 8:1 result select are
// built from 2-input NAND cells.
module nand_fn_unit
    import nand_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    logic [OP_W-1:0] op_n;
    logic [7:0]      dec;

    for (genvar k = 0; k < OP_W; k++) begin : g_op_inv
        assign op_n[k] = nand2(op[k], op[k]);
    end

    // One-hot opcode decode, shared by all bit slices.
    for (genvar j = 0; j < 8; j++) begin : g_dec
        localparam logic [2:0] Code = 3'(j);
        logic l0, l1, l2;
        assign l0     = Code[0] ? op[0] : op_n[0];
        assign l1     = Code[1] ? op[1] : op_n[1];
        assign l2     = Code[2] ? op[2] : op_n[2];
        assign dec[j] = and2(and2(l0, l1), l2);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic       ab_n, a_n, b_n, x1, x2;
        logic       f_and, f_or, f_nor, f_xor, f_xnor, f_pass;
        logic [7:0] f, term_n;

        assign ab_n   = nand2(a[i], b[i]);
        assign a_n    = nand2(a[i], a[i]);
        assign b_n    = nand2(b[i], b[i]);
        assign x1     = nand2(a[i], ab_n);
        assign x2     = nand2(b[i], ab_n);

        assign f_and  = nand2(ab_n, ab_n);
        assign f_or   = nand2(a_n, b_n);
        assign f_nor  = nand2(f_or, f_or);
        assign f_xor  = nand2(x1, x2);
        assign f_xnor = nand2(f_xor, f_xor);
        assign f_pass = nand2(a_n, a_n);

        assign f = {f_pass, a_n, f_xnor, f_xor, f_nor, f_or, f_and, ab_n};

        for (genvar j = 0; j < 8; j++) begin : g_term
            assign term_n[j] = nand2(dec[j], f[j]);
        end

        // OR of the gated terms = NAND of their complements.
        assign y[i] = nand2(and2(and2(term_n[0], term_n[1]), and2(term_n[2], term_n[3])),
                            and2(and2(term_n[4], term_n[5]), and2(term_n[6], term_n[7])));
    end

endmodule

// File: rtl/nand_logic_pipe.sv
// Pipelined NAND-built logic unit with valid/ready back-pressure on both sides
// and a wrapping count of output handshakes.
module nand_logic_pipe
    import nand_pipe_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [OP_W-1:0]    in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic [OP_W-1:0]    out_op,
    output logic [COUNT_W-1:0] op_count
);

    localparam int unsigned Last = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0] v_q;
    logic [PIPE_STAGES-1:0] adv;
    logic [WIDTH-1:0]       y_q  [PIPE_STAGES];
    logic [OP_W-1:0]        op_q [PIPE_STAGES];
    logic [COUNT_W-1:0]     count_q;
    logic [WIDTH-1:0]       fn_y;

    nand_fn_unit #(
        .WIDTH(WIDTH)
    ) u_fn (
        .a  (in_a),
        .b  (in_b),
        .op (in_op),
        .y  (fn_y)
    );

    // Stage i may advance if the output is taken or any stage at or after i is empty;
    // this is the unrolled form of adv[i] = !v[i] | adv[i+1].
    always_comb begin
        adv = '0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            adv[i] = out_ready | (|(~v_q >> i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                y_q[i]  <= '0;
                op_q[i] <= '0;
            end
        end else begin
            if (adv[0]) begin
                v_q[0]  <= in_valid;
                y_q[0]  <= fn_y;
                op_q[0] <= in_op;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                if (adv[i]) begin
                    v_q[i]  <= v_q[i-1];
                    y_q[i]  <= y_q[i-1];
                    op_q[i] <= op_q[i-1];
                end
            end
            if (v_q[Last] && out_ready) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[Last];
    assign out_y     = y_q[Last];
    assign out_op    = op_q[Last];
    assign op_count  = count_q;

endmodule
